// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_phy_pkg
//  Description : Shared PCIe PHY receive definitions. Holds the K28.5 comma
//                codes, the symbol width, the aligner state encoding and a
//                bit-reversal helper for the 10b symbol window.
//  Revision    : 1.0  initial release
// ============================================================================
package pcie_phy_pkg;

    localparam int               SYM_BITS  = 10;
    localparam logic [SYM_BITS-1:0] K28_5_NEG = 10'h17C;  // K28.5, RD-
    localparam logic [SYM_BITS-1:0] K28_5_POS = 10'h283;  // K28.5, RD+

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    function automatic logic [SYM_BITS-1:0] bit_rev(input logic [SYM_BITS-1:0] v);
        logic [SYM_BITS-1:0] r;
        for (int i = 0; i < SYM_BITS; i++) begin
            r[i] = v[SYM_BITS-1-i];
        end
        return r;
    endfunction

endpackage : pcie_phy_pkg
`default_nettype wire

// File: rtl/pcie_comma_detect.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_comma_detect
//  Description : Combinational K28.5 comma detector. Orients the 10-bit
//                window (optionally bit-reversed) and flags either running
//                disparity form of K28.5.
//  Ports       : i_win         10-bit window, oldest received bit in [0]
//                i_bit_reverse 1: first received bit belongs in symbol bit 9
//                o_sym         oriented symbol (what the parallel side sees)
//                o_is_comma    1 when o_sym is 17C or 283
//  Revision    : 1.0  initial release
// ============================================================================
module pcie_comma_detect
    import pcie_phy_pkg::*;
(
    input  logic [SYM_BITS-1:0] i_win,
    input  logic                i_bit_reverse,
    output logic [SYM_BITS-1:0] o_sym,
    output logic                o_is_comma
);

    always_comb begin
        o_sym      = i_bit_reverse ? bit_rev(i_win) : i_win;
        o_is_comma = (o_sym == K28_5_NEG) || (o_sym == K28_5_POS);
    end

endmodule : pcie_comma_detect
`default_nettype wire

// File: rtl/pcie_rx_symbol_align.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_rx_symbol_align
//  Description : Per-lane serial receive aligner. Shifts the bit-rate lane
//                into a 10-bit window, locks the symbol boundary to K28.5
//                commas (HUNT -> CHECK -> LOCKED) and strobes aligned 10b
//                symbols out to the parallel receive path.
//  Build macro : PCIE_RX_ALIGN_IDLE_EN - when defined, IDLE_BITS consecutive
//                high-impedance bits declare electrical idle. When undefined
//                there is no idle logic, z/x bits shift in as 0 and ElecIdle
//                is tied low.
//  Parameters  : LOCK_COUNT   aligned commas needed to lock       (1..15)
//                UNLOCK_COUNT misaligned commas tolerated locked   (1..15)
//                IDLE_BITS    z bits declaring electrical idle
//  Ports       : SerClk     bit clock, all state on rising edge
//                notReset   asynchronous active-low reset
//                SerIn      serial lane bit (first bit of symbol = 'a')
//                BitReverse 1: first received bit maps to ParOut[9]
//                ParOut     aligned symbol
//                ParValid   one-cycle strobe, ParOut updated this cycle
//                Locked     1 while in LOCKED
//                ElecIdle   1 while lane is electrically idle
//                AlignErr   one-cycle pulse per misaligned comma in LOCKED
//  Revision    : 1.0  initial release
// ============================================================================
module pcie_rx_symbol_align
    import pcie_phy_pkg::*;
#(
    parameter int LOCK_COUNT   = 2,
    parameter int UNLOCK_COUNT = 4,
    parameter int IDLE_BITS    = 10
) (
    input  logic                SerClk,
    input  logic                notReset,
    input  logic                SerIn,
    input  logic                BitReverse,
    output logic [SYM_BITS-1:0] ParOut,
    output logic                ParValid,
    output logic                Locked,
    output logic                ElecIdle,
    output logic                AlignErr
);

    localparam logic [3:0] c_lock_count   = 4'(LOCK_COUNT);
    localparam logic [3:0] c_unlock_count = 4'(UNLOCK_COUNT);
    localparam logic [3:0] c_last_bit     = 4'(SYM_BITS - 1);

    if (LOCK_COUNT < 1 || LOCK_COUNT > 15 || UNLOCK_COUNT < 1 || UNLOCK_COUNT > 15
        || IDLE_BITS < 1) begin : g_param_check
        $error("pcie_rx_symbol_align: parameter out of range");
    end

    // Registered state
    align_state_e        r_state;
    logic [SYM_BITS-2:0] r_hist;       // last 9 received bits, oldest in [0]
    logic [3:0]          r_bit_cnt;
    logic [3:0]          r_good_cnt;
    logic [3:0]          r_bad_cnt;
    logic                r_br_prev;
    logic [SYM_BITS-1:0] r_par_out;
    logic                r_par_valid;
    logic                r_align_err;

    // Combinational
    align_state_e        w_state_next;
    logic                w_bit;
    logic [SYM_BITS-1:0] w_win_next;
    logic [SYM_BITS-1:0] w_sym;
    logic                w_is_comma;
    logic                w_boundary;
    logic [3:0]          w_bit_cnt_next;
    logic [3:0]          w_good_next;
    logic [3:0]          w_bad_next;
    logic [3:0]          w_good_inc;
    logic [3:0]          w_bad_inc;
    logic                w_par_valid_next;
    logic                w_par_load;
    logic                w_align_err_next;
    logic                w_idle_hold;

    // Only a driven '1' counts as one; z/x resolve to 0.
    assign w_bit      = (SerIn === 1'b1);
    assign w_boundary = (r_bit_cnt == c_last_bit);
    assign w_good_inc = (r_good_cnt == 4'hF) ? r_good_cnt : r_good_cnt + 4'd1;
    assign w_bad_inc  = (r_bad_cnt  == 4'hF) ? r_bad_cnt  : r_bad_cnt  + 4'd1;

`ifdef PCIE_RX_ALIGN_IDLE_EN
    localparam int                c_idle_w    = $clog2(IDLE_BITS + 1);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_BITS - 1);

    logic                r_elec_idle;
    logic [c_idle_w-1:0] r_idle_cnt;
    logic                w_is_z;
    logic                w_idle_declare;
    logic                w_resume;

    assign w_is_z         = (SerIn === 1'bz);
    assign w_idle_declare = w_is_z && !r_elec_idle && (r_idle_cnt == c_idle_last);
    assign w_idle_hold    = w_is_z && (r_elec_idle || w_idle_declare);
    assign w_resume       = !w_is_z && r_elec_idle;
    // Leaving idle, the window restarts empty so stale pre-idle bits cannot
    // combine with new data into a false comma.
    assign w_win_next     = w_resume ? {w_bit, {(SYM_BITS-1){1'b0}}} : {w_bit, r_hist};

    always_ff @(posedge SerClk or negedge notReset) begin
        if (!notReset) begin
            r_elec_idle <= 1'b0;
            r_idle_cnt  <= '0;
        end else begin
            if (!w_is_z) begin
                r_idle_cnt <= '0;
            end else if (!r_elec_idle) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_idle_declare) begin
                r_elec_idle <= 1'b1;
            end else if (!w_is_z) begin
                r_elec_idle <= 1'b0;
            end
        end
    end

    assign ElecIdle = r_elec_idle;
    assign ParOut   = r_elec_idle ? {SYM_BITS{1'bz}} : r_par_out;
`else
    assign w_idle_hold = 1'b0;
    assign w_win_next  = {w_bit, r_hist};
    assign ElecIdle    = 1'b0;
    assign ParOut      = r_par_out;
`endif

    // The comma check looks at the window including the bit arriving this
    // cycle, so a symbol is delivered one cycle after its last bit.
    pcie_comma_detect u_comma_detect (
        .i_win         (w_win_next),
        .i_bit_reverse (BitReverse),
        .o_sym         (w_sym),
        .o_is_comma    (w_is_comma)
    );

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = w_boundary ? 4'd0 : r_bit_cnt + 4'd1;
        w_good_next      = r_good_cnt;
        w_bad_next       = r_bad_cnt;
        w_par_valid_next = w_boundary && (r_state == LOCKED);
        w_par_load       = w_boundary;
        w_align_err_next = 1'b0;

        if (BitReverse != r_br_prev) begin
            // Orientation changed: every previous boundary decision is void.
            w_state_next     = HUNT;
            w_good_next      = 4'd0;
            w_bad_next       = 4'd0;
            w_par_valid_next = 1'b0;
        end else if (w_is_comma) begin
            case (r_state)
                HUNT: begin
                    w_bit_cnt_next = 4'd0;
                    w_good_next    = 4'd1;
                    w_bad_next     = 4'd0;
                    w_state_next   = (c_lock_count == 4'd1) ? LOCKED : CHECK;
                end
                CHECK: begin
                    if (w_boundary) begin
                        w_good_next = w_good_inc;
                        if (w_good_inc == c_lock_count) begin
                            w_state_next = LOCKED;
                            w_bad_next   = 4'd0;
                        end
                    end else begin
                        w_bit_cnt_next = 4'd0;
                        w_good_next    = 4'd1;
                    end
                end
                LOCKED: begin
                    if (w_boundary) begin
                        w_bad_next = 4'd0;
                    end else begin
                        // Tolerated error: boundary is kept, no re-phase.
                        w_align_err_next = 1'b1;
                        w_bad_next       = w_bad_inc;
                        if (w_bad_inc == c_unlock_count) begin
                            w_state_next = HUNT;
                            w_good_next  = 4'd0;
                            w_bad_next   = 4'd0;
                        end
                    end
                end
                default: begin
                    w_state_next = HUNT;
                end
            endcase
        end

        if (w_idle_hold) begin
            w_state_next     = HUNT;
            w_bit_cnt_next   = 4'd0;
            w_good_next      = 4'd0;
            w_bad_next       = 4'd0;
            w_par_valid_next = 1'b0;
            w_par_load       = 1'b0;
            w_align_err_next = 1'b0;
        end
    end

    always_ff @(posedge SerClk or negedge notReset) begin
        if (!notReset) begin
            r_state     <= HUNT;
            r_hist      <= '0;
            r_bit_cnt   <= 4'd0;
            r_good_cnt  <= 4'd0;
            r_bad_cnt   <= 4'd0;
            r_br_prev   <= 1'b0;
            r_par_out   <= '0;
            r_par_valid <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_good_cnt  <= w_good_next;
            r_bad_cnt   <= w_bad_next;
            r_br_prev   <= BitReverse;
            r_par_valid <= w_par_valid_next;
            r_align_err <= w_align_err_next;
            if (!w_idle_hold) begin
                r_hist <= w_win_next[SYM_BITS-1:1];
            end
            if (w_par_load) begin
                r_par_out <= w_sym;
            end
        end
    end

    assign ParValid = r_par_valid;
    assign AlignErr = r_align_err;
    assign Locked   = (r_state == LOCKED);

endmodule : pcie_rx_symbol_align
`default_nettype wire

// File: tb/tb_pcie_rx_symbol_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcie_rx_symbol_align
//  Description : Self-checking bench for pcie_rx_symbol_align. Expected
//                symbols are queued as stimulus is sent and popped whenever
//                the DUT strobes ParValid. Idle scenario is built only with
//                PCIE_RX_ALIGN_IDLE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pcie_rx_symbol_align;

    logic       SerClk;
    logic       notReset;
    logic       SerIn;
    logic       BitReverse;
    wire  [9:0] ParOut;
    wire        ParValid;
    wire        Locked;
    wire        ElecIdle;
    wire        AlignErr;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         last_strobe = -1;
    int         align_err_cnt = 0;
    bit         sb_en  = 1'b0;
    bit         gap_en = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_sym;

    pcie_rx_symbol_align dut (
        .SerClk     (SerClk),
        .notReset   (notReset),
        .SerIn      (SerIn),
        .BitReverse (BitReverse),
        .ParOut     (ParOut),
        .ParValid   (ParValid),
        .Locked     (Locked),
        .ElecIdle   (ElecIdle),
        .AlignErr   (AlignErr)
    );

    initial begin
        SerClk = 1'b0;
        forever #5 SerClk = ~SerClk;
    end

    // Scoreboard monitor: samples 1 time unit after each rising edge.
    always @(posedge SerClk) begin
        #1;
        cyc = cyc + 1;
        if (AlignErr === 1'b1) align_err_cnt = align_err_cnt + 1;
        if (ParValid === 1'b1) begin
            if (gap_en && last_strobe >= 0) begin
                total = total + 1;
                if ((cyc - last_strobe) !== 10) begin
                    bad = bad + 1;
                    $display("FAIL strobe_gap: got %0d cycles, want 10", cyc - last_strobe);
                end
            end
            last_strobe = cyc;
            if (sb_en) begin
                total = total + 1;
                if (exp_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_strobe: ParOut=%h, none expected", ParOut);
                end else begin
                    exp_sym = exp_q.pop_front();
                    if (ParOut !== exp_sym) begin
                        bad = bad + 1;
                        $display("FAIL par_out: got %h, want %h", ParOut, exp_sym);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        SerIn = b;
        @(posedge SerClk);
        #3;
    endtask

    // Sends one symbol in wire order; with BitReverse=1 symbol bit 9 goes first.
    task automatic send_sym(input logic [9:0] sym, input bit expect_strobe);
        if (expect_strobe) exp_q.push_back(sym);
        for (int i = 0; i < 10; i++) begin
            send_bit(BitReverse ? sym[9-i] : sym[i]);
        end
    endtask

    task automatic test_reset;
        notReset   = 1'b0;
        SerIn      = 1'b0;
        BitReverse = 1'b0;
        repeat (2) @(posedge SerClk);
        #3;
        total = total + 5;
        if (ParOut !== 10'h000) begin bad = bad + 1; $display("FAIL reset_parout: got %h, want 000", ParOut); end
        if (ParValid !== 1'b0)  begin bad = bad + 1; $display("FAIL reset_parvalid: got %b, want 0", ParValid); end
        if (Locked !== 1'b0)    begin bad = bad + 1; $display("FAIL reset_locked: got %b, want 0", Locked); end
        if (ElecIdle !== 1'b0)  begin bad = bad + 1; $display("FAIL reset_elecidle: got %b, want 0", ElecIdle); end
        if (AlignErr !== 1'b0)  begin bad = bad + 1; $display("FAIL reset_alignerr: got %b, want 0", AlignErr); end
        notReset = 1'b1;
    endtask

    task automatic test_lock;
        sb_en = 1'b1;
        gap_en = 1'b1;
        last_strobe = -1;
        repeat (3) send_bit(1'b0);          // phase offset 3
        send_sym(10'h17C, 1'b0);
        total = total + 1;
        if (Locked !== 1'b0) begin bad = bad + 1; $display("FAIL lock_after_c1: got %b, want 0", Locked); end
        send_sym(10'h283, 1'b0);
        total = total + 1;
        if (Locked !== 1'b1) begin bad = bad + 1; $display("FAIL lock_after_c2: got %b, want 1", Locked); end
        send_sym(10'h17C, 1'b1);
        total = total + 2;
        if (Locked !== 1'b1) begin bad = bad + 1; $display("FAIL lock_after_c3: got %b, want 1", Locked); end
        if (exp_q.size() !== 0) begin bad = bad + 1; $display("FAIL lock_missing_strobe: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_data_stream;
        int e0;
        e0 = align_err_cnt;
        for (int i = 0; i < 8; i++) send_sym(10'h2AA, 1'b1);
        total = total + 3;
        if (Locked !== 1'b1) begin bad = bad + 1; $display("FAIL data_locked: got %b, want 1", Locked); end
        if (align_err_cnt !== e0) begin bad = bad + 1; $display("FAIL data_alignerr: got %0d, want %0d", align_err_cnt, e0); end
        if (exp_q.size() !== 0) begin bad = bad + 1; $display("FAIL data_missing_strobe: %0d left, want 0", exp_q.size()); end
        gap_en = 1'b0;
    endtask

    task automatic test_misalign;
        int e0;
        sb_en = 1'b0;                       // boundaries now straddle the commas
        e0 = align_err_cnt;
        send_bit(1'b0);                     // slip the stream by one bit
        for (int i = 0; i < 4; i++) begin
            send_sym((i % 2) ? 10'h283 : 10'h17C, 1'b0);
            total = total + 2;
            if (align_err_cnt !== e0 + i + 1) begin
                bad = bad + 1;
                $display("FAIL misalign_err_%0d: got %0d, want %0d", i, align_err_cnt, e0 + i + 1);
            end
            if (Locked !== ((i < 3) ? 1'b1 : 1'b0)) begin
                bad = bad + 1;
                $display("FAIL misalign_locked_%0d: got %b, want %b", i, Locked, (i < 3));
            end
        end
        send_sym(10'h17C, 1'b0);
        total = total + 1;
        if (Locked !== 1'b0) begin bad = bad + 1; $display("FAIL relock_c1: got %b, want 0", Locked); end
        send_sym(10'h283, 1'b0);
        total = total + 2;
        if (Locked !== 1'b1) begin bad = bad + 1; $display("FAIL relock_c2: got %b, want 1", Locked); end
        if (align_err_cnt !== e0 + 4) begin bad = bad + 1; $display("FAIL relock_alignerr: got %0d, want %0d", align_err_cnt, e0 + 4); end
        exp_q.delete();
        sb_en = 1'b1;
        send_sym(10'h17C, 1'b1);
        total = total + 1;
        if (exp_q.size() !== 0) begin bad = bad + 1; $display("FAIL relock_missing_strobe: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_bit_reverse;
        BitReverse = 1'b1;
        send_bit(1'b0);
        total = total + 1;
        if (Locked !== 1'b0) begin bad = bad + 1; $display("FAIL rev_toggle_unlock: got %b, want 0", Locked); end
        send_sym(10'h17C, 1'b0);
        total = total + 1;
        if (Locked !== 1'b0) begin bad = bad + 1; $display("FAIL rev_c1: got %b, want 0", Locked); end
        send_sym(10'h283, 1'b0);
        total = total + 1;
        if (Locked !== 1'b1) begin bad = bad + 1; $display("FAIL rev_c2: got %b, want 1", Locked); end
        send_sym(10'h17C, 1'b1);
        total = total + 1;
        if (exp_q.size() !== 0) begin bad = bad + 1; $display("FAIL rev_missing_strobe: %0d left, want 0", exp_q.size()); end
        BitReverse = 1'b0;
        send_bit(1'b0);
        total = total + 1;
        if (Locked !== 1'b0) begin bad = bad + 1; $display("FAIL rev_back_unlock: got %b, want 0", Locked); end
    endtask

`ifdef PCIE_RX_ALIGN_IDLE_EN
    task automatic test_idle;
        repeat (9) send_bit(1'bz);
        total = total + 1;
        if (ElecIdle !== 1'b0) begin bad = bad + 1; $display("FAIL idle_early: got %b, want 0", ElecIdle); end
        send_bit(1'bz);
        total = total + 3;
        if (ElecIdle !== 1'b1)        begin bad = bad + 1; $display("FAIL idle_set: got %b, want 1", ElecIdle); end
        if (ParOut !== 10'bzzzzzzzzzz) begin bad = bad + 1; $display("FAIL idle_parout: got %b, want z", ParOut); end
        if (Locked !== 1'b0)          begin bad = bad + 1; $display("FAIL idle_locked: got %b, want 0", Locked); end
        send_sym(10'h17C, 1'b0);
        total = total + 1;
        if (ElecIdle !== 1'b0) begin bad = bad + 1; $display("FAIL idle_clear: got %b, want 0", ElecIdle); end
        send_sym(10'h283, 1'b0);
        total = total + 1;
        if (Locked !== 1'b1) begin bad = bad + 1; $display("FAIL idle_relock: got %b, want 1", Locked); end
        send_sym(10'h17C, 1'b1);
        total = total + 1;
        if (exp_q.size() !== 0) begin bad = bad + 1; $display("FAIL idle_missing_strobe: %0d left, want 0", exp_q.size()); end
    endtask
`endif

    task automatic test_async_reset;
        notReset = 1'b0;
        #2;
        notReset = 1'b1;
        send_sym(10'h17C, 1'b0);
        send_sym(10'h283, 1'b0);
        total = total + 1;
        if (Locked !== 1'b1) begin bad = bad + 1; $display("FAIL arst_prelock: got %b, want 1", Locked); end
        send_sym(10'h17C, 1'b1);
        total = total + 1;
        if (ParValid !== 1'b1) begin bad = bad + 1; $display("FAIL arst_pre_strobe: got %b, want 1", ParValid); end
        #1;
        notReset = 1'b0;                    // mid-cycle, no clock edge follows yet
        #1;
        total = total + 6;
        if (ParOut !== 10'h000) begin bad = bad + 1; $display("FAIL arst_parout: got %h, want 000", ParOut); end
        if (ParValid !== 1'b0)  begin bad = bad + 1; $display("FAIL arst_parvalid: got %b, want 0", ParValid); end
        if (Locked !== 1'b0)    begin bad = bad + 1; $display("FAIL arst_locked: got %b, want 0", Locked); end
        if (ElecIdle !== 1'b0)  begin bad = bad + 1; $display("FAIL arst_elecidle: got %b, want 0", ElecIdle); end
        if (AlignErr !== 1'b0)  begin bad = bad + 1; $display("FAIL arst_alignerr: got %b, want 0", AlignErr); end
        if (exp_q.size() !== 0) begin bad = bad + 1; $display("FAIL arst_missing_strobe: %0d left, want 0", exp_q.size()); end
        #2;
        notReset = 1'b1;
        send_bit(1'b0);
        total = total + 1;
        if (Locked !== 1'b0) begin bad = bad + 1; $display("FAIL arst_post_locked: got %b, want 0", Locked); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_data_stream();
        test_misalign();
        test_bit_reverse();
`ifdef PCIE_RX_ALIGN_IDLE_EN
        test_idle();
`endif
        test_async_reset();
        repeat (3) @(posedge SerClk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pcie_rx_symbol_align
`default_nettype wire
